// File: rtl/mult4b_ctrl_pkg.sv
// Shared constants, FSM encoding and the iteration-counter increment helper
// for the shift-and-add multiplier controller.
package mult4b_ctrl_pkg;

    localparam int OP_W  = 4;
    localparam int CNT_W = $clog2(OP_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bitwise ripple increment so the iteration counter needs no adder operator.
    function automatic logic [CNT_W-1:0] count_inc(input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] r;
        logic             carry;
        r     = '0;
        carry = 1'b1;
        for (int i = 0; i < CNT_W; i++) begin
            r[i]  = c[i] ^ carry;
            carry = c[i] & carry;
        end
        return r;
    endfunction

endpackage

// File: rtl/mult4b_ctrl_sum4b.sv
// Ripple-carry adder shared by every partial-product step of the multiplier.
module sum4b
    import mult4b_ctrl_pkg::*;
#(
    parameter int W = OP_W
) (
    input  logic [W-1:0] xi,
    input  logic [W-1:0] yi,
    output logic         co,
    output logic [W-1:0] zi
);

    logic [W:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign zi[i]  = xi[i] ^ yi[i] ^ c[i];
        assign c[i+1] = (xi[i] & yi[i]) | (c[i] & (xi[i] ^ yi[i]));
    end

    assign co = c[W];

endmodule

// File: rtl/mult4b_ctrl.sv
// Unsigned W x W shift-and-add multiplier: IDLE -> CALC (W steps) -> DONE,
// one shared adder, product register updated only when a result completes.
module mult4b_ctrl
    import mult4b_ctrl_pkg::*;
#(
    parameter int W = OP_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           init,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    output logic [2*W-1:0] pp,
    output logic           busy,
    output logic           done
);

    state_t             state;
    state_t             state_next;
    logic [2*W-1:0]     acc;
    logic [2*W-1:0]     acc_next;
    logic [W-1:0]       mcand;
    logic [W-1:0]       addend;
    logic [W-1:0]       zi;
    logic               co;
    logic [CNT_W-1:0]   count;
    logic               last_step;

    // Multiplicand is added only when the multiplier bit now in acc[0] is set.
    assign addend    = acc[0] ? mcand : '0;
    assign acc_next  = {co, zi, acc[W-1:1]};
    assign last_step = (count == CNT_W'(W - 1));

    sum4b #(.W(W)) u_sum4b (
        .xi (acc[2*W-1:W]),
        .yi (addend),
        .co (co),
        .zi (zi)
    );

    // NOTE: every register below uses <= so all of them update from the same
    // pre-edge values; blocking assignments here would chain within one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            mcand <= '0;
            count <= '0;
            pp    <= '0;
        end else begin
            state <= state_next;
            unique case (state)
                IDLE: begin
                    if (init) begin
                        mcand <= A;
                        acc   <= {{W{1'b0}}, B};
                        count <= '0;
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    count <= count_inc(count);
                    if (last_step) begin
                        pp <= acc_next;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: defaults come first so every path assigns every output and no
    // latch is inferred.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (init) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
